// File: rtl/md5_scheduler.sv
// rtl/md5_scheduler.sv - round-robin job scheduler and completion queue for an array of MD5 cores
module md5_scheduler #(
  parameter int NUM_UNITS = 32,
  parameter int IDX_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 job_valid,
  output logic                 job_ready,
  output logic [IDX_W-1:0]     job_unit,
  input  logic                 abort,
  output logic [NUM_UNITS-1:0] md5_reset,
  output logic [NUM_UNITS-1:0] md5_start,
  input  logic [NUM_UNITS-1:0] md5_done,
  output logic                 cmp_valid,
  output logic [IDX_W-1:0]     cmp_unit,
  input  logic                 cmp_ready,
  output logic [NUM_UNITS-1:0] busy_mask
);

  // Per-core lifecycle: reserved from accept until the host pops its completion.
  typedef enum logic [2:0] {
    FREE = 3'd0,
    RST  = 3'd1,
    STRT = 3'd2,
    RUN  = 3'd3,
    PEND = 3'd4,
    CPL  = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNITS - 1);

  state_t               state [NUM_UNITS];
  logic [IDX_W-1:0]     rr_ptr;

  logic [IDX_W-1:0]     fifo_mem [NUM_UNITS];
  logic [IDX_W-1:0]     wr_ptr;
  logic [IDX_W-1:0]     rd_ptr;
  logic [IDX_W:0]       count;

  logic [NUM_UNITS-1:0] free_mask;
  logic [NUM_UNITS-1:0] pend_mask;
  logic                 pend_any;
  logic [IDX_W-1:0]     pend_idx;
  logic                 accept;
  logic                 push;
  logic                 pop;

  // Index increment that wraps at NUM_UNITS, which need not be a power of two.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    if (v == LAST_IDX) begin
      return '0;
    end
    return v + 1'b1;
  endfunction

  // First set bit of 'free' at or after 'start', searching upward with wrap-around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_UNITS-1:0] free,
                                               input logic [IDX_W-1:0]     start);
    logic [IDX_W-1:0] pick;
    logic             hit;
    int               c;
    pick = '0;
    hit  = 1'b0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      c = int'(start) + k;
      if (c >= NUM_UNITS) begin
        c = c - NUM_UNITS;
      end
      if (!hit && free[c[IDX_W-1:0]]) begin
        hit  = 1'b1;
        pick = c[IDX_W-1:0];
      end
    end
    return pick;
  endfunction

  // busy_mask is kept in lockstep with the state array, so its inverse is the free set.
  assign free_mask = ~busy_mask;
  assign job_unit  = rr_pick(free_mask, rr_ptr);
  assign job_ready = (|free_mask) && !abort;
  assign accept    = job_valid && job_ready;

  assign cmp_valid = (count != '0);
  assign cmp_unit  = cmp_valid ? fifo_mem[rd_ptr] : '0;
  assign pop       = cmp_valid && cmp_ready && !abort;
  assign push      = pend_any && !abort;

  // Decode which cores wait for a completion slot and pick the lowest-index one.
  always_comb begin
    pend_mask = '0;
    pend_any  = 1'b0;
    pend_idx  = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      pend_mask[i] = (state[i] == PEND);
    end
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (pend_mask[i]) begin
        pend_any = 1'b1;
        pend_idx = IDX_W'(i);
      end
    end
  end

  // Completion storage; contents are don't-care while the queue is empty.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      fifo_mem[wr_ptr] <= pend_idx;
    end
  end

  // Core state machines, pulse outputs, round-robin pointer and queue pointers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        state[i] <= FREE;
      end
      md5_reset <= '0;
      md5_start <= '0;
      busy_mask <= '0;
      rr_ptr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else if (abort) begin
      // Flush: every core is reset once more so stale done levels clear.
      for (int i = 0; i < NUM_UNITS; i++) begin
        state[i] <= FREE;
      end
      md5_reset <= '1;
      md5_start <= '0;
      busy_mask <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      md5_reset <= '0;
      md5_start <= '0;

      for (int i = 0; i < NUM_UNITS; i++) begin
        case (state[i])
          RST: begin
            state[i]     <= STRT;
            md5_start[i] <= 1'b1;
          end
          STRT: begin
            state[i] <= RUN;
          end
          RUN: begin
            if (md5_done[i]) begin
              state[i] <= PEND;
            end
          end
          default: begin
          end
        endcase
      end

      // Accept, push and pop always target cores in distinct states, so they never collide.
      if (push) begin
        state[pend_idx] <= CPL;
        wr_ptr          <= wrap_inc(wr_ptr);
      end

      if (pop) begin
        state[cmp_unit]     <= FREE;
        busy_mask[cmp_unit] <= 1'b0;
        rd_ptr              <= wrap_inc(rd_ptr);
      end

      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end

      if (accept) begin
        state[job_unit]     <= RST;
        md5_reset[job_unit] <= 1'b1;
        busy_mask[job_unit] <= 1'b1;
        rr_ptr              <= wrap_inc(job_unit);
      end
    end
  end

endmodule

// File: doc/md5_scheduler.md
Name: md5_scheduler

Overview:
- Sequences and shares an array of NUM_UNITS MD5 cores among incoming hash jobs.
- Accepts jobs on a valid/ready port and assigns each to a free core in round-robin order.
- For each assigned core, drives a one-cycle reset pulse, then a one-cycle start pulse, then waits for done.
- Reports finished core indices through a completion FIFO. A core is held reserved until its completion entry is popped, which is when the host has read its result. Sits between the host-side job interface and the per-core md5_reset/md5_start/md5_done vectors.

Parameters:
- NUM_UNITS, 32, number of MD5 cores; width of the start/reset/done vectors.
- IDX_W, 5, core index width; must satisfy 2**IDX_W >= NUM_UNITS.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- job_valid  input  1  host offers a job.
- job_ready  output  1  a core is free; a job is accepted when job_valid && job_ready.
- job_unit  output  IDX_W  index of the core the offered job will receive; valid while job_ready=1.
- abort  input  1  one-cycle request to flush all work.
- md5_reset  output  NUM_UNITS  per-core reset pulses (registered).
- md5_start  output  NUM_UNITS  per-core start pulses (registered).
- md5_done  input  NUM_UNITS  per-core done levels; cleared by that core's reset.
- cmp_valid  output  1  completion FIFO not empty.
- cmp_unit  output  IDX_W  index of the finished core at the FIFO head.
- cmp_ready  input  1  host pops the head when cmp_valid && cmp_ready.
- busy_mask  output  NUM_UNITS  1 for each core not in FREE.

Behaviour:
- Per-core FSM states: FREE, RST, STRT, RUN, PEND, CPL.
- Reset (reset=0 at a clk edge): all cores FREE; md5_reset=0, md5_start=0, busy_mask=0; FIFO empty (cmp_valid=0, cmp_unit=0); round-robin pointer=0; job_ready reflects all cores free (1).
- Allocation:
  - job_unit is the first FREE core at or after the rr pointer, searching upward with wrap-around.
  - job_ready=1 iff any core is FREE and abort=0.
  - On accept, that core goes FREE->RST and the rr pointer becomes job_unit+1 modulo NUM_UNITS.
  - At most one job is accepted per cycle.
- Sequencing, with accept at edge E:
  - md5_reset[i]=1 for exactly the cycle after E (state RST).
  - md5_start[i]=1 for exactly the following cycle (state STRT).
  - The core then enters RUN. Minimum accept-to-start latency is 2 cycles.
- Done detection:
  - In RUN, a sampled md5_done[i]=1 moves the core to PEND.
  - md5_done is ignored in FREE, RST and STRT.
- Completion enqueue:
  - Each cycle, the lowest-index PEND core is pushed into the FIFO and moves to CPL; one push per cycle.
  - Other PEND cores wait; no completion is lost.
- Completion FIFO:
  - Depth NUM_UNITS. At most NUM_UNITS cores can be outstanding, so it can never overflow.
  - First-word fall-through: cmp_unit is valid in the same cycle cmp_valid=1.
  - A push and a pop may occur in the same cycle; the count is unchanged.
  - A push into an empty FIFO makes cmp_valid=1 on the next cycle.
- Pop: the popped core moves CPL->FREE at that edge and may be re-allocated from the next cycle.
- Abort (abort=1 at an edge) overrides accept, push and pop in that cycle:
  - All cores go to FREE; the FIFO is emptied.
  - md5_reset is all ones for the next cycle; md5_start=0 for that cycle.
  - The rr pointer is preserved.
  - A job offered during the abort cycle is not accepted (job_ready=0).
- busy_mask[i] is registered and equals (state!=FREE).
- Reset asserted mid-operation behaves exactly as the reset case above: no trailing pulses, and in-flight completions are discarded.

Test Plan:
- NUM_UNITS=4, after reset, hold job_valid=1 for 4 cycles -> job_unit sequence 0,1,2,3. md5_reset shows one-hot 0001,0010,0100,1000 one cycle after each accept. Each start pulse follows its reset pulse by 1 cycle. Then job_ready=0 and busy_mask=1111.
- All 4 cores running; raise md5_done=1010 in one cycle with cmp_ready=0 -> FIFO receives 1 then 3 on consecutive cycles. cmp_valid=1, cmp_unit=1, busy_mask stays 1111.
- Pop core 1 (cmp_ready=1 for one cycle) -> cmp_unit=3 next. job_ready=1 with job_unit=1. Accepting re-pulses md5_reset[1].
- Cores 0 and 2 FREE, rr pointer=1 -> job_unit=2; after that accept, job_unit=0 (wrap-around).
- Pulse abort with 3 cores busy, 1 entry queued, and job_valid=1 -> no accept that cycle. Next cycle md5_reset=1111, md5_start=0000, cmp_valid=0, busy_mask=0000.
- Drive reset=0 one cycle after an accept (before its start pulse) -> no md5_start pulse ever appears. All outputs are 0 and job_ready=1 after reset.
